// File: rtl/cache_refill_if.sv
// Lookup/refill bus bundle: request, response, way array and memory ports.
// slave = controller view, master = requester/storage/memory side.
interface cache_refill_if #(
  parameter int WAY_NUM     = 2,
  parameter int CACHE_DEPTH = 128,
  parameter int INDEX_WIDTH = $clog2(CACHE_DEPTH),
  parameter int TAG_WIDTH   = 20,
  parameter int LINE_WIDTH  = 128,
  parameter int ENTRY_WIDTH = TAG_WIDTH + LINE_WIDTH
);
  logic                            i_req_valid;
  logic                            o_req_ready;
  logic [INDEX_WIDTH-1:0]          i_req_idx;
  logic [TAG_WIDTH-1:0]            i_req_tag;
  logic                            o_rsp_valid;
  logic                            i_rsp_ready;
  logic [LINE_WIDTH-1:0]           o_rsp_data;
  logic                            o_rsp_hit;
  logic [INDEX_WIDTH-1:0]          o_way_ridx;
  logic [WAY_NUM*(1+ENTRY_WIDTH)-1:0] i_way_rdata;
  logic [WAY_NUM-1:0]              o_way_wren;
  logic [INDEX_WIDTH-1:0]          o_way_widx;
  logic [ENTRY_WIDTH-1:0]          o_way_wdata;
  logic                            o_mem_req_valid;
  logic                            i_mem_req_ready;
  logic [TAG_WIDTH+INDEX_WIDTH-1:0] o_mem_req_addr;
  logic                            i_mem_rsp_valid;
  logic [LINE_WIDTH-1:0]           i_mem_rsp_data;

  modport slave (
    input  i_req_valid, i_req_idx, i_req_tag,
    input  i_rsp_ready, i_way_rdata,
    input  i_mem_req_ready, i_mem_rsp_valid,
    input  i_mem_rsp_data,
    output o_req_ready, o_rsp_valid, o_rsp_data,
    output o_rsp_hit, o_way_ridx, o_way_wren,
    output o_way_widx, o_way_wdata,
    output o_mem_req_valid, o_mem_req_addr
  );

  modport master (
    output i_req_valid, i_req_idx, i_req_tag,
    output i_rsp_ready, i_way_rdata,
    output i_mem_req_ready, i_mem_rsp_valid,
    output i_mem_rsp_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data,
    input  o_rsp_hit, o_way_ridx, o_way_wren,
    input  o_way_widx, o_way_wdata,
    input  o_mem_req_valid, o_mem_req_addr
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Single-outstanding cache lookup with miss refill and victim choice.
// Ports: clk, rst_n (async low) and bus (cache_refill_if.slave).
module cache_refill_ctrl #(
  parameter int WAY_NUM     = 2,
  parameter int CACHE_DEPTH = 128,
  parameter int INDEX_WIDTH = $clog2(CACHE_DEPTH),
  parameter int TAG_WIDTH   = 20,
  parameter int LINE_WIDTH  = 128,
  parameter int ENTRY_WIDTH = TAG_WIDTH + LINE_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  cache_refill_if.slave bus
);
  localparam int WW  = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam int EW1 = ENTRY_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MEM_REQ, MEM_WAIT, REFILL, RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [LINE_WIDTH-1:0]  line_q, line_d;
  logic                   hit_q, hit_d;
  logic [WW-1:0]          victim_q, victim_d;
  logic                   use_rr_q, use_rr_d;
  logic [WW-1:0]          rr_q, rr_d;

  logic                   hit_any;
  logic [LINE_WIDTH-1:0]  hit_line;
  logic                   inv_any;
  logic [WW-1:0]          inv_way;

  // Descending scan so the lowest-index match wins.
  always_comb begin
    hit_any  = 1'b0;
    hit_line = '0;
    inv_any  = 1'b0;
    inv_way  = '0;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (bus.i_way_rdata[w*EW1 + ENTRY_WIDTH] &&
          bus.i_way_rdata[w*EW1 + LINE_WIDTH +: TAG_WIDTH]
            == tag_q) begin
        hit_any  = 1'b1;
        hit_line = bus.i_way_rdata[w*EW1 +: LINE_WIDTH];
      end
      if (!bus.i_way_rdata[w*EW1 + ENTRY_WIDTH]) begin
        inv_any = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tag_d    = tag_q;
    line_d   = line_q;
    hit_d    = hit_q;
    victim_d = victim_q;
    use_rr_d = use_rr_q;
    rr_d     = rr_q;
    unique case (state_q)
      IDLE: if (bus.i_req_valid) begin
        idx_d   = bus.i_req_idx;
        tag_d   = bus.i_req_tag;
        state_d = LOOKUP;
      end
      LOOKUP: if (hit_any) begin
        line_d  = hit_line;
        hit_d   = 1'b1;
        state_d = RESP;
      end else begin
        hit_d    = 1'b0;
        victim_d = inv_any ? inv_way : rr_q;
        use_rr_d = !inv_any;
        state_d  = MEM_REQ;
      end
      MEM_REQ: if (bus.i_mem_req_ready) begin
        state_d = MEM_WAIT;
      end
      MEM_WAIT: if (bus.i_mem_rsp_valid) begin
        line_d  = bus.i_mem_rsp_data;
        state_d = REFILL;
      end
      REFILL: begin
        if (use_rr_q) rr_d = rr_q + WW'(1);
        state_d = RESP;
      end
      RESP: if (bus.i_rsp_ready) begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tag_q    <= '0;
      line_q   <= '0;
      hit_q    <= 1'b0;
      victim_q <= '0;
      use_rr_q <= 1'b0;
      rr_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tag_q    <= tag_d;
      line_q   <= line_d;
      hit_q    <= hit_d;
      victim_q <= victim_d;
      use_rr_q <= use_rr_d;
      rr_q     <= rr_d;
    end
  end

  assign bus.o_req_ready     = (state_q == IDLE);
  assign bus.o_rsp_valid     = (state_q == RESP);
  assign bus.o_rsp_data      = line_q;
  assign bus.o_rsp_hit       = hit_q;
  assign bus.o_way_ridx      = idx_q;
  assign bus.o_way_widx      = idx_q;
  assign bus.o_way_wdata     = {tag_q, line_q};
  assign bus.o_mem_req_valid = (state_q == MEM_REQ);
  assign bus.o_mem_req_addr  = {tag_q, idx_q};
  assign bus.o_way_wren      = (state_q == REFILL)
                             ? (WAY_NUM'(1) << victim_q)
                             : '0;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a behavioural way store.
// Drives the master side of cache_refill_if; checks at negedges.
module tb_cache_refill_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;
  int   wr_cnt = 0;
  int   w0;

  always #5 clk = ~clk;

  cache_refill_if bus ();

  cache_refill_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [255:0] mv = '0;
  logic [19:0]  mt [0:255];
  logic [127:0] ml [0:255];

  always_comb begin
    bus.i_way_rdata = '0;
    for (int w = 0; w < 2; w++) begin
      bus.i_way_rdata[w*149 +: 149] = {
        mv[w*128 + int'(bus.o_way_ridx)],
        mt[w*128 + int'(bus.o_way_ridx)],
        ml[w*128 + int'(bus.o_way_ridx)]};
    end
  end

  always @(posedge clk) begin
    if (bus.o_way_wren != 2'b00) wr_cnt <= wr_cnt + 1;
    for (int w = 0; w < 2; w++) begin
      if (bus.o_way_wren[w]) begin
        mv[w*128 + int'(bus.o_way_widx)] <= 1'b1;
        mt[w*128 + int'(bus.o_way_widx)] <=
          bus.o_way_wdata[147:128];
        ml[w*128 + int'(bus.o_way_widx)] <=
          bus.o_way_wdata[127:0];
      end
    end
  end

  task automatic chk(input string tg,
                     input logic [299:0] obs,
                     input logic [299:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tg, obs, exp);
    end
  endtask

  task automatic send(input logic [6:0] idx,
                      input logic [19:0] tg);
    int n = 0;
    @(negedge clk);
    while (!bus.o_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", bus.o_req_ready, 1'b1);
    bus.i_req_valid = 1'b1;
    bus.i_req_idx   = idx;
    bus.i_req_tag   = tg;
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
  endtask

  task automatic hit(input logic [6:0] idx,
                     input logic [19:0] tg,
                     input logic [127:0] d);
    send(idx, tg);
    @(negedge clk);
    chk("hit_lookup", bus.o_rsp_valid, 1'b0);
    @(negedge clk);
    chk("hit_valid", bus.o_rsp_valid, 1'b1);
    chk("hit_flag", bus.o_rsp_hit, 1'b1);
    chk("hit_data", bus.o_rsp_data, d);
    chk("hit_nomem", bus.o_mem_req_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic miss(input logic [6:0] idx,
                      input logic [19:0] tg,
                      input logic [127:0] d,
                      input logic [1:0] wren);
    send(idx, tg);
    @(negedge clk);
    chk("miss_lookup",
        {bus.o_mem_req_valid, bus.o_rsp_valid}, 2'b00);
    @(negedge clk);
    chk("mreq_valid", bus.o_mem_req_valid, 1'b1);
    chk("mreq_addr", bus.o_mem_req_addr, {tg, idx});
    @(negedge clk);
    chk("mreq_done", bus.o_mem_req_valid, 1'b0);
    bus.i_mem_rsp_valid = 1'b1;
    bus.i_mem_rsp_data  = d;
    @(posedge clk);
    #1 bus.i_mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("wren", bus.o_way_wren, wren);
    chk("widx", bus.o_way_widx, idx);
    chk("wdata", bus.o_way_wdata, {tg, d});
    @(negedge clk);
    chk("miss_valid", bus.o_rsp_valid, 1'b1);
    chk("miss_flag", bus.o_rsp_hit, 1'b0);
    chk("miss_data", bus.o_rsp_data, d);
    chk("wren_once", bus.o_way_wren, 2'b00);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] da5;
    da5 = {16{8'hA5}};
    bus.i_req_valid     = 1'b0;
    bus.i_req_idx       = '0;
    bus.i_req_tag       = '0;
    bus.i_rsp_ready     = 1'b1;
    bus.i_mem_req_ready = 1'b1;
    bus.i_mem_rsp_valid = 1'b0;
    bus.i_mem_rsp_data  = '0;
    #3;
    chk("rst_ready", bus.o_req_ready, 1'b1);
    chk("rst_rsp", {bus.o_rsp_valid, bus.o_rsp_hit}, 2'b00);
    chk("rst_data", bus.o_rsp_data, 128'h0);
    chk("rst_wren", bus.o_way_wren, 2'b00);
    chk("rst_idx", {bus.o_way_ridx, bus.o_way_widx}, 14'h0);
    chk("rst_wdata", bus.o_way_wdata, 148'h0);
    chk("rst_mreq", bus.o_mem_req_valid, 1'b0);
    chk("rst_addr", bus.o_mem_req_addr, 27'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    miss(7'd5, 20'h12345, da5, 2'b01);
    hit(7'd5, 20'h12345, da5);

    miss(7'd7, 20'h1, {4{32'h1111_1111}}, 2'b01);
    miss(7'd7, 20'h2, {4{32'h2222_2222}}, 2'b10);
    miss(7'd7, 20'h3, {4{32'h3333_3333}}, 2'b01);
    miss(7'd7, 20'h4, {4{32'h4444_4444}}, 2'b10);
    hit(7'd7, 20'h3, {4{32'h3333_3333}});
    hit(7'd7, 20'h4, {4{32'h4444_4444}});

    bus.i_mem_req_ready = 1'b0;
    bus.i_rsp_ready     = 1'b0;
    w0 = wr_cnt;
    send(7'd9, 20'h55);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_mreq_v", bus.o_mem_req_valid, 1'b1);
      chk("bp_addr", bus.o_mem_req_addr, {20'h55, 7'd9});
    end
    bus.i_mem_req_ready = 1'b1;
    @(negedge clk);
    chk("bp_mreq_done", bus.o_mem_req_valid, 1'b0);
    bus.i_mem_rsp_valid = 1'b1;
    bus.i_mem_rsp_data  = {4{32'h9999_0000}};
    @(posedge clk);
    #1 bus.i_mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("bp_wren", bus.o_way_wren, 2'b01);
    repeat (4) begin
      @(negedge clk);
      chk("bp_rsp_v", bus.o_rsp_valid, 1'b1);
      chk("bp_rsp_d", bus.o_rsp_data, {4{32'h9999_0000}});
      chk("bp_rsp_h", bus.o_rsp_hit, 1'b0);
    end
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle", bus.o_req_ready, 1'b1);
    chk("bp_pulses", wr_cnt - w0, 1);

    send(7'd11, 20'h77);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", bus.o_req_ready, 1'b1);
    chk("mid_rst_mreq", bus.o_mem_req_valid, 1'b0);
    chk("mid_rst_data", bus.o_rsp_data, 128'h0);
    w0 = wr_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.i_mem_rsp_valid = 1'b1;
    bus.i_mem_rsp_data  = {4{32'hDEAD_BEEF}};
    @(posedge clk);
    #1 bus.i_mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("late_wren", bus.o_way_wren, 2'b00);
    chk("late_ready", bus.o_req_ready, 1'b1);
    chk("late_pulses", wr_cnt - w0, 0);
    miss(7'd11, 20'h77, {4{32'h7777_0000}}, 2'b01);

    w0 = wr_cnt;
    @(negedge clk);
    bus.i_mem_rsp_valid = 1'b1;
    bus.i_mem_rsp_data  = {4{32'hBAD0_BAD0}};
    @(posedge clk);
    #1 bus.i_mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("stray_idle_rdy", bus.o_req_ready, 1'b1);
    chk("stray_idle_out",
        {bus.o_rsp_valid, bus.o_mem_req_valid, bus.o_way_wren},
        4'b0000);
    chk("stray_idle_d", bus.o_rsp_data, {4{32'h7777_0000}});
    send(7'd5, 20'h12345);
    bus.i_mem_rsp_valid = 1'b1;
    @(negedge clk);
    chk("stray_lk_v", bus.o_rsp_valid, 1'b0);
    @(posedge clk);
    #1 bus.i_mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("stray_lk_rsp", {bus.o_rsp_valid, bus.o_rsp_hit}, 2'b11);
    chk("stray_lk_d", bus.o_rsp_data, da5);
    chk("stray_pulses", wr_cnt - w0, 0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Lookup and refill controller that sits directly upstream of the per-way cache storage arrays. It accepts one lookup request at a time and drives the shared read index to all ways. It compares the returned tags, and on a hit returns the line. On a miss it fetches the line from memory, writes it into a victim way, and returns the refilled line.

## Interface
- WAY_NUM, 2, number of ways (≥2, power of two)
- CACHE_DEPTH, 128, sets per way
- INDEX_WIDTH, $clog2(CACHE_DEPTH), set index width
- TAG_WIDTH, 20, tag width
- LINE_WIDTH, 128, line data width
- ENTRY_WIDTH, TAG_WIDTH+LINE_WIDTH, stored payload per entry, {tag, line}
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  lookup request valid
- o_req_ready  out  1  request accepted when valid&ready
- i_req_idx  in  INDEX_WIDTH  set index
- i_req_tag  in  TAG_WIDTH  tag
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumed when valid&ready
- o_rsp_data  out  LINE_WIDTH  line data
- o_rsp_hit  out  1  1 = hit, 0 = served by refill
- o_way_ridx  out  INDEX_WIDTH  read index, shared by all ways
- i_way_rdata  in  WAY_NUM*(1+ENTRY_WIDTH)  way w occupies slice w, formatted {valid, tag, line}; combinational w.r.t. o_way_ridx
- o_way_wren  out  WAY_NUM  one-hot write enable
- o_way_widx  out  INDEX_WIDTH  write index
- o_way_wdata  out  ENTRY_WIDTH  {tag, line}; a write sets the entry's valid bit
- o_mem_req_valid  out  1  line fetch request
- i_mem_req_ready  in  1  fetch accepted
- o_mem_req_addr  out  TAG_WIDTH+INDEX_WIDTH  {tag, idx}
- i_mem_rsp_valid  in  1  fetch data valid, single beat
- i_mem_rsp_data  in  LINE_WIDTH  fetched line

## Operation
- FSM states: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, REFILL, RESP.
- IDLE: o_req_ready=1. On valid&ready, latch idx/tag and go to LOOKUP.
- o_way_ridx always equals the latched idx. o_way_widx equals the latched idx.
- LOOKUP: hit[w] = valid_w & (tag_w == latched tag).
  - Any hit: latch that way's line and go to RESP with o_rsp_hit=1.
  - Several hits (illegal, must not crash): lowest-index way wins.
  - No hit: go to MEM_REQ.
- MEM_REQ: o_mem_req_valid=1, with addr held stable until i_mem_req_ready, then go to MEM_WAIT.
- MEM_WAIT: on i_mem_rsp_valid, latch the data and go to REFILL.
- REFILL: assert o_way_wren[victim] for exactly one cycle, with wdata = {latched tag, latched line}. Then go to RESP with o_rsp_hit=0 and o_rsp_data = refilled line.
- Victim selection, computed from the LOOKUP-cycle way data and latched with the miss decision:
  - If any way is invalid, pick the lowest-index invalid way.
  - Otherwise pick way rr_ptr.
- rr_ptr ($clog2(WAY_NUM) bits) increments (wrapping modulo WAY_NUM) only on a refill that used it.
- RESP: o_rsp_valid=1 with data and hit held stable until i_rsp_ready, then go to IDLE.
- Only one request is outstanding at a time. i_req_valid is ignored outside IDLE.
- i_mem_rsp_valid outside MEM_WAIT is ignored; no state change, no write.

## Timing
- Reset values:
  - State IDLE, rr_ptr 0.
  - o_req_ready=1; o_rsp_valid=0; o_rsp_hit=0; o_rsp_data=0.
  - o_way_wren=0; o_way_ridx=0; o_way_widx=0; o_way_wdata=0.
  - o_mem_req_valid=0; o_mem_req_addr=0.
- Hit: request accepted at cycle T, LOOKUP at T+1, o_rsp_valid at T+2 (with i_rsp_ready=1, back to IDLE at T+3).
- Miss, with i_mem_req_ready=1 immediately:
  - Accept at T, LOOKUP at T+1, o_mem_req_valid at T+2.
  - Response at cycle M → wren at M+1, o_rsp_valid at M+2.
- A following lookup to the same set observes the refilled entry, because the write completes before IDLE is re-entered.
- Reset asserted in any state returns immediately (asynchronously) to reset values. Any in-flight fetch is abandoned, and a late memory response is ignored.
- All outputs are registered or pure decodes of the state; there is no combinational path from i_rsp_ready or i_mem_req_ready to any valid output.

## Test plan
- Cold miss: all ways invalid, request idx=5 tag=0x12345, memory returns 0xA5…A5.
  - o_mem_req_addr={0x12345,5}.
  - o_way_wren=2'b01, widx=5.
  - Response data=0xA5…A5, hit=0.
- Hit after fill: repeat idx=5 tag=0x12345 → o_rsp_valid exactly 2 cycles after accept, hit=1, data=0xA5…A5, no mem request.
- Replacement:
  - Fill tags 1 and 2 into set 7: expect ways 0 and 1.
  - Miss on tag 3 → victim way rr_ptr=0.
  - Miss on tag 4 → victim way 1.
- Backpressure: hold i_mem_req_ready=0 for 5 cycles and i_rsp_ready=0 for 4 cycles → valid held and addr/data stable throughout, exactly one wren pulse.
- Reset mid-miss: assert rst_n=0 in MEM_WAIT, then deliver i_mem_rsp_valid after release → no wren, o_req_ready=1, next lookup misses normally.
- Stray response: i_mem_rsp_valid pulsed while in IDLE or LOOKUP → no state or output change.
